// File: rtl/kamikaze_mem_arbiter.sv
// Shares one single-ported synchronous RAM between instruction fetch and the LSU.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX denials.
module kamikaze_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_be_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BE_W  = 4;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_D    = 2'd2
  } resp_e;

  resp_e            resp_owner;
  resp_e            resp_owner_next;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             starved;

  // Word-aligned RAM: the byte-offset bits of both address ports are ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr_i[1:0], d_addr_i[1:0]};

  // Arbitration: data wins unless fetch has been starved long enough.
  assign starved  = (starve_cnt == CNT_W'(STARVE_MAX));
  assign if_gnt_o = if_req_i & (~d_req_i | starved);
  assign d_gnt_o  = d_req_i & ~if_gnt_o;

  // Memory command mux driven straight from the winning requester.
  always_comb begin
    mem_req_o   = if_gnt_o | d_gnt_o;
    mem_we_o    = 1'b0;
    mem_be_o    = BE_W'(0);
    mem_wdata_o = d_wdata_i;
    mem_addr_o  = {d_addr_i[ADDR_W-1:2], 2'b00};
    if (if_gnt_o) begin
      mem_be_o   = {BE_W{1'b1}};
      mem_addr_o = {if_addr_i[ADDR_W-1:2], 2'b00};
    end else if (d_gnt_o) begin
      mem_we_o = d_we_i;
      mem_be_o = d_be_i;
    end
  end

  // Starvation counter: counts denied fetch cycles, clears on grant or idle.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (if_gnt_o || !if_req_i) begin
      starve_cnt_next = CNT_W'(0);
    end else if (!starved) begin
      starve_cnt_next = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt <= CNT_W'(0);
    end else begin
      starve_cnt <= starve_cnt_next;
    end
  end

  // Response owner register: remembers who owns the RAM read data next cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      resp_owner <= RESP_NONE;
    end else begin
      resp_owner <= resp_owner_next;
    end
  end

  always_comb begin
    resp_owner_next = RESP_NONE;
    if_rvalid_o     = 1'b0;
    d_rvalid_o      = 1'b0;
    if (if_gnt_o) begin
      resp_owner_next = RESP_IF;
    end else if (d_gnt_o) begin
      resp_owner_next = RESP_D;
    end
    case (resp_owner)
      RESP_IF: if_rvalid_o = 1'b1;
      RESP_D:  d_rvalid_o  = 1'b1;
      default: ;
    endcase
  end

  // Read data is only meaningful alongside the matching rvalid.
  assign if_rdata_o = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;

endmodule
